// File: rtl/tone_envelope_if.sv
// Sample/control bundle between the tone path driver (master) and the
// envelope stage (slave).
interface tone_envelope_if #(
  parameter int N = 8,
  parameter int G = 6
);
  logic         fs_tick;
  logic         note_on;
  logic         note_off;
  logic [N-1:0] pos_in;
  logic [N-1:0] neg_in;
  logic [N-1:0] pos_out;
  logic [N-1:0] neg_out;
  logic [G:0]   gain_o;
  logic         busy;

  modport master (
    output fs_tick, note_on, note_off, pos_in, neg_in,
    input  pos_out, neg_out, gain_o, busy
  );

  modport slave (
    input  fs_tick, note_on, note_off, pos_in, neg_in,
    output pos_out, neg_out, gain_o, busy
  );
endinterface

// File: rtl/tone_envelope.sv
// Attack/decay/sustain/release amplitude envelope for the half-wave tone
// samples. Gain is a G+1 bit fraction where 2^G is unity, ramped one LSB per
// prescaled fs step so note starts and stops are click-free.
module tone_envelope #(
  parameter int N       = 8,
  parameter int G       = 6,
  parameter int ATK_DIV = 16,
  parameter int REL_DIV = 32,
  parameter int SUS_LVL = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  tone_envelope_if.slave       bus
);

  localparam int DIV_MAX = (ATK_DIV > REL_DIV) ? ATK_DIV : REL_DIV;
  localparam int PW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int PWID    = N + G + 1;

  localparam logic [G:0]    UNITY  = {1'b1, {G{1'b0}}};
  localparam logic [G:0]    SUS    = (G+1)'(SUS_LVL);
  localparam logic [PW-1:0] ATK_M1 = PW'(ATK_DIV - 1);
  localparam logic [PW-1:0] REL_M1 = PW'(REL_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [G:0]    gain_q, gain_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] div_m1;
  logic [G:0]    gain_inc, gain_dec;
  logic          ramping;
  logic          step;

  assign gain_inc = gain_q + (G+1)'(1);
  assign gain_dec = gain_q - (G+1)'(1);

  // State, gain and prescaler registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      gain_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      presc_q <= presc_d;
    end
  end

  // Next-state, gain ramp and prescaler; note events outrank the step.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    gain_d  = gain_q;
    presc_d = presc_q;
    div_m1  = (state_q == S_RELEASE) ? REL_M1 : ATK_M1;
    ramping = state_q inside {S_ATTACK, S_DECAY, S_RELEASE};
    step    = bus.fs_tick && ramping && (presc_q == div_m1);

    if (bus.note_on) begin
      // Retrigger keeps the current gain so the ramp has no discontinuity.
      state_d = S_ATTACK;
      presc_d = '0;
    end else if (bus.note_off &&
                 (state_q inside {S_ATTACK, S_DECAY, S_SUSTAIN})) begin
      state_d = S_RELEASE;
      presc_d = '0;
    end else begin
      if (ramping && bus.fs_tick) begin
        presc_d = step ? '0 : presc_q + PW'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          gain_d  = '0;
          presc_d = '0;
        end
        S_ATTACK: begin
          if (step) begin
            // A retrigger from full scale must not step past unity.
            if (gain_q >= UNITY) begin
              gain_d  = UNITY;
              state_d = (SUS == UNITY) ? S_SUSTAIN : S_DECAY;
            end else begin
              gain_d = gain_inc;
              if (gain_inc == UNITY) begin
                state_d = (SUS == UNITY) ? S_SUSTAIN : S_DECAY;
              end
            end
          end
        end
        S_DECAY: begin
          if (step) begin
            if (gain_q <= SUS) begin
              gain_d  = SUS;
              state_d = S_SUSTAIN;
            end else begin
              gain_d = gain_dec;
              if (gain_dec == SUS) begin
                state_d = S_SUSTAIN;
              end
            end
          end
        end
        S_SUSTAIN: begin
          gain_d  = SUS;
          presc_d = '0;
        end
        S_RELEASE: begin
          // Already silent on entry: leave without waiting for a step.
          if (gain_q == '0) begin
            state_d = S_IDLE;
          end else if (step) begin
            gain_d = gain_dec;
            if (gain_dec == '0) begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          gain_d  = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Scaled outputs use the gain held before this cycle's update.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pos_out <= '0;
      bus.neg_out <= '0;
    end else begin
      bus.pos_out <= N'((PWID'(bus.pos_in) * PWID'(gain_q)) >> G);
      bus.neg_out <= N'((PWID'(bus.neg_in) * PWID'(gain_q)) >> G);
    end
  end

  assign bus.gain_o = gain_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tone_envelope.sv
// Directed bench for tone_envelope: three instances (sustain 48, 64, 0)
// share fs_tick and samples; each has its own note pulses.
module tb_tone_envelope;

  logic       clk = 1'b0;
  logic       reset;
  logic       fs_tick;
  logic [2:0] note_on;
  logic [2:0] note_off;
  logic [7:0] pos_in;
  logic [7:0] neg_in;

  int tests_run = 0;
  int tests_failed = 0;
  int ph = 0;
  int ft_cnt = 0;
  int ticks;
  int quiet;

  always #5 clk = ~clk;

  tone_envelope_if #(.N(8), .G(6)) a_if ();
  tone_envelope_if #(.N(8), .G(6)) b_if ();
  tone_envelope_if #(.N(8), .G(6)) c_if ();

  assign a_if.fs_tick = fs_tick;  assign a_if.note_on = note_on[0];
  assign a_if.note_off = note_off[0];
  assign a_if.pos_in = pos_in;    assign a_if.neg_in = neg_in;
  assign b_if.fs_tick = fs_tick;  assign b_if.note_on = note_on[1];
  assign b_if.note_off = note_off[1];
  assign b_if.pos_in = pos_in;    assign b_if.neg_in = neg_in;
  assign c_if.fs_tick = fs_tick;  assign c_if.note_on = note_on[2];
  assign c_if.note_off = note_off[2];
  assign c_if.pos_in = pos_in;    assign c_if.neg_in = neg_in;

  tone_envelope #(.N(8), .G(6), .ATK_DIV(2), .REL_DIV(4), .SUS_LVL(48)) u_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  tone_envelope #(.N(8), .G(6), .ATK_DIV(2), .REL_DIV(4), .SUS_LVL(64)) u_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));
  tone_envelope #(.N(8), .G(6), .ATK_DIV(2), .REL_DIV(4), .SUS_LVL(0)) u_c (
    .clk(clk), .reset(reset), .bus(c_if.slave));

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gain_of(input int w);
    case (w)
      0:       return int'(a_if.gain_o);
      1:       return int'(b_if.gain_o);
      default: return int'(c_if.gain_o);
    endcase
  endfunction

  function automatic int busy_of(input int w);
    case (w)
      0:       return int'(a_if.busy);
      1:       return int'(b_if.busy);
      default: return int'(c_if.busy);
    endcase
  endfunction

  // One clk; fs_tick is high every fourth cycle. Sampling is 1 time unit
  // after the edge.
  task automatic step_clk();
    fs_tick = (ph == 3);
    @(posedge clk);
    #1;
    if (fs_tick) ft_cnt++;
    ph = (ph + 1) % 4;
  endtask

  task automatic run_clks(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  // Advance to the cycle whose edge will see fs_tick high.
  task automatic goto_tick();
    while (ph != 3) step_clk();
  endtask

  task automatic pulse(input logic [2:0] on_m, input logic [2:0] off_m);
    note_on  = on_m;
    note_off = off_m;
    step_clk();
    note_on  = '0;
    note_off = '0;
  endtask

  // Run until gain of instance w equals val; returns fs ticks seen since the
  // caller cleared ft_cnt, or -1 on timeout.
  task automatic wait_gain(input int w, input int val, input int max_clk,
                           output int n_ticks);
    int n = 0;
    while (gain_of(w) != val && n < max_clk) begin
      step_clk();
      n++;
    end
    n_ticks = (gain_of(w) == val) ? ft_cnt : -1;
  endtask

  initial begin
    reset    = 1'b1;
    fs_tick  = 1'b0;
    note_on  = '0;
    note_off = '0;
    pos_in   = 8'd200;
    neg_in   = 8'd100;
    run_clks(3);
    reset = 1'b0;

    // Reset state.
    check("rst_gain", gain_of(0), 0);
    check("rst_busy", busy_of(0), 0);
    check("rst_pos", int'(a_if.pos_out), 0);

    // 1: idle for 100 fs ticks, every instance stays silent.
    quiet = 0;
    for (int i = 0; i < 400; i++) begin
      step_clk();
      quiet |= gain_of(0) | gain_of(1) | gain_of(2) | busy_of(0) | busy_of(1)
             | busy_of(2) | int'(a_if.pos_out) | int'(a_if.neg_out);
    end
    check("idle_quiet", quiet, 0);

    // 2: full envelope on instance a.
    pulse(3'b001, 3'b000);
    check("attack_busy", busy_of(0), 1);
    ft_cnt = 0;
    wait_gain(0, 64, 1000, ticks);
    check("attack_ticks", ticks, 128);
    ft_cnt = 0;
    step_clk();
    check("peak_pos", int'(a_if.pos_out), 200);
    check("peak_neg", int'(a_if.neg_out), 100);
    wait_gain(0, 48, 400, ticks);
    check("decay_ticks", ticks, 32);
    step_clk();
    check("sus_pos", int'(a_if.pos_out), 150);
    check("sus_neg", int'(a_if.neg_out), 75);
    run_clks(200);
    check("sus_hold", gain_of(0), 48);
    pulse(3'b000, 3'b001);
    ft_cnt = 0;
    wait_gain(0, 0, 1200, ticks);
    check("release_ticks", ticks, 192);
    check("release_busy", busy_of(0), 0);
    step_clk();
    check("release_pos", int'(a_if.pos_out), 0);

    // 3: retrigger during release at gain 20.
    pulse(3'b001, 3'b000);
    wait_gain(0, 48, 1500, ticks);
    pulse(3'b000, 3'b001);
    wait_gain(0, 20, 1000, ticks);
    pulse(3'b001, 3'b000);
    check("retrig_hold", gain_of(0), 20);
    check("retrig_busy", busy_of(0), 1);
    ft_cnt = 0;
    wait_gain(0, 21, 100, ticks);
    check("retrig_step", ticks, 2);
    ft_cnt = 0;
    wait_gain(0, 64, 1000, ticks);
    check("retrig_peak", ticks, 86);

    // 4a: note_on and note_off together in sustain -> attack.
    wait_gain(0, 48, 400, ticks);
    pulse(3'b001, 3'b001);
    ft_cnt = 0;
    wait_gain(0, 49, 100, ticks);
    check("on_wins_off", ticks, 2);

    // 4b: note_off on a decay step cycle -> release, gain unchanged.
    wait_gain(0, 64, 1000, ticks);
    goto_tick();
    step_clk();
    check("decay_pre", gain_of(0), 64);
    goto_tick();
    pulse(3'b000, 3'b001);
    check("off_vs_step", gain_of(0), 64);
    ft_cnt = 0;
    wait_gain(0, 63, 100, ticks);
    check("rel_rate", ticks, 4);

    // 5: reset mid-attack at gain 30.
    wait_gain(0, 0, 1500, ticks);
    pulse(3'b001, 3'b000);
    ft_cnt = 0;
    wait_gain(0, 30, 500, ticks);
    check("pre_reset_ticks", ticks, 60);
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    check("mid_rst_gain", gain_of(0), 0);
    check("mid_rst_busy", busy_of(0), 0);
    step_clk();
    check("mid_rst_pos", int'(a_if.pos_out), 0);
    check("mid_rst_neg", int'(a_if.neg_out), 0);

    // 6a: sustain at unity skips decay.
    pulse(3'b010, 3'b000);
    ft_cnt = 0;
    wait_gain(1, 64, 1000, ticks);
    check("u64_attack", ticks, 128);
    run_clks(40);
    check("u64_hold", gain_of(1), 64);
    check("u64_busy", busy_of(1), 1);
    check("u64_pos", int'(b_if.pos_out), 200);
    pulse(3'b000, 3'b010);
    ft_cnt = 0;
    wait_gain(1, 0, 2000, ticks);
    check("u64_release", ticks, 256);
    check("u64_idle", busy_of(1), 0);

    // 6b: sustain at zero, then note_off reaches idle one cycle after release.
    pulse(3'b100, 3'b000);
    wait_gain(2, 64, 1000, ticks);
    ft_cnt = 0;
    wait_gain(2, 0, 1000, ticks);
    check("z_decay", ticks, 128);
    run_clks(40);
    check("z_hold", gain_of(2), 0);
    check("z_busy", busy_of(2), 1);
    pulse(3'b000, 3'b100);
    check("z_rel_busy", busy_of(2), 1);
    step_clk();
    check("z_idle", busy_of(2), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
